uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants, FSM encoding and divider helper for uart_rx
package uart_rx_pkg;

  localparam int          DATA_W  = 8;
  localparam logic [15:0] MIN_DIV = 16'd2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  // Clamp tiny dividers so the half-bit count never drops below MIN_DIV.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-stage synchronizer for an asynchronous input
module uart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Reset to the idle line level so no false edge appears after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with start-bit glitch rejection and break handling
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       clock_div,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_error,
  output logic              rx_busy
);

  localparam int              INIT_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(SYNC_STAGES);

  logic              rx_s;
  logic [2:0]        state_q, state_d;
  logic [15:0]       h_q, h_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic [INIT_W-1:0] init_q, init_d;
  logic              armed_q, armed_d;
  logic              tick;
  logic [16:0]       two_h;

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // The counter counts h..1 (or 2h..1); the action fires on the last count.
  assign tick  = (cnt_q <= 17'd1);
  assign two_h = {h_q, 1'b0};

  // Next-state logic: frame sequencing, sampling and output pulse generation.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    init_d  = init_q;
    armed_d = armed_q;
    case (state_q)
      ST_IDLE: begin
        if (!armed_q) begin
          // Wait until the synchronizer holds real line samples, then refuse
          // to treat a line that is already low as a start edge.
          if (init_q == INIT_DONE) begin
            armed_d = 1'b1;
            if (!rx_s) state_d = ST_WAIT_HIGH;
          end else begin
            init_d = init_q + INIT_W'(1);
          end
        end else if (!rx_s) begin
          h_d     = eff_div(clock_div);
          cnt_d   = {1'b0, eff_div(clock_div)};
          bit_d   = 3'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_d   = two_h;
            state_d = ST_DATA;
          end else begin
            cnt_d   = 17'd0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = two_h;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          // Leaving at the stop midpoint leaves half a bit to catch the next start.
          cnt_d = 17'd0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight without a pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      h_q     <= 16'd0;
      cnt_q   <= 17'd0;
      bit_q   <= 3'd0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      init_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      init_q  <= init_d;
      armed_q <= armed_d;
    end
  end

  assign rx_data        = data_q;
  assign rx_valid       = valid_q;
  assign rx_frame_error = ferr_q;
  assign rx_busy        = (state_q != ST_IDLE);

endmodule
